// File: rtl/gsensor_spi_responder_pkg.sv
// gsensor_pkg: shared constants for the G-sensor SPI responder.
//   - register addresses of the implemented ADXL345-style subset
//   - register bit positions used by the datapath
//   - FSM state encodings (plain localparams for legacy tool flows)
//   - is_data_addr(): true for the DATAX0..DATAZ1 window
package gsensor_pkg;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
    localparam logic [5:0] ADDR_INT_MAP     = 6'h2F;
    localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAX1      = 6'h33;
    localparam logic [5:0] ADDR_DATAY0      = 6'h34;
    localparam logic [5:0] ADDR_DATAY1      = 6'h35;
    localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

    localparam int MEASURE_BIT    = 3;
    localparam int DATA_READY_BIT = 7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CMD   = 2'd1;
    localparam logic [1:0] ST_WDATA = 2'd2;
    localparam logic [1:0] ST_RDATA = 2'd3;

    function automatic logic is_data_addr(input logic [5:0] a);
        return (a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1);
    endfunction

endpackage

// File: rtl/gsensor_spi_responder_if.sv
// gsensor_spi_responder_if: 4-wire SPI bus between a controller and the
// G-sensor responder.
//   spi_csn     chip select, active low        (controller -> responder)
//   spi_sclk    serial clock, idles high       (controller -> responder)
//   spi_sdi     controller-to-responder data   (controller -> responder)
//   spi_sdo     responder-to-controller data   (responder -> controller)
//   spi_sdo_oe  SDO output enable              (responder -> controller)
interface gsensor_spi_responder_if;
    logic spi_csn;
    logic spi_sclk;
    logic spi_sdi;
    logic spi_sdo;
    logic spi_sdo_oe;

    modport master (
        output spi_csn, spi_sclk, spi_sdi,
        input  spi_sdo, spi_sdo_oe
    );

    modport slave (
        input  spi_csn, spi_sclk, spi_sdi,
        output spi_sdo, spi_sdo_oe
    );
endinterface

// File: rtl/gsensor_spi_responder_spi_edge_sync.sv
// spi_edge_sync: multi-flop synchronizer for an asynchronous SPI pin, with
// single-cycle rise/fall pulses derived from the synchronized level.
//   clk, reset  system clock, synchronous active-high reset
//   din         asynchronous pin
//   rise, fall  one-cycle pulses on synchronized edges
// RESET_VAL sets the level the chain assumes during reset; choosing it
// deliberately lets the parent suppress (or accept) an edge right after reset.
module spi_edge_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~prev;
    assign fall = ~chain[STAGES-1] & prev;
endmodule

// File: rtl/gsensor_spi_responder.sv
// gsensor_spi_responder: stand-in for the board accelerometer. Answers SPI
// mode 3 frames with an ADXL345-style command byte (R/W, MB, addr[5:0]),
// holds a small register subset and raises DATA_READY on INT1/INT2.
//   clk, reset        system clock, synchronous active-high reset
//   spi               SPI bus (slave modport): csn, sclk, sdi, sdo, sdo_oe
//   sample_x/y/z      signed acceleration sample
//   sample_valid      one-cycle strobe offering a sample
//   int_out[1]/[2]    INT1 / INT2, active high
//
// state  | meaning
// IDLE   | CSN high (or frame aborted by reset); waiting for CSN to fall
// CMD    | shifting in the command byte on SCLK rising edges
// WDATA  | shifting in write data bytes; write on each 8th rising edge
// RDATA  | shifting out read data on SCLK falling edges, MSB first
module gsensor_spi_responder
    import gsensor_pkg::*;
#(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter logic [7:0] BW_RATE_RST = 8'h0A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    gsensor_spi_responder_if.slave spi,
    input  logic signed [15:0]    sample_x,
    input  logic signed [15:0]    sample_y,
    input  logic signed [15:0]    sample_z,
    input  logic                  sample_valid,
    output logic [2:1]            int_out
);
    localparam int STG = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic sclk_rise, sclk_fall, csn_rise, csn_fall;
    logic [STG-1:0] sdi_chain;
    logic sdi_s;

    spi_edge_sync #(.STAGES(STG), .RESET_VAL(1'b1)) u_sclk_sync (
        .clk  (clk),
        .reset(reset),
        .din  (spi.spi_sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // CSN chain resets low: if reset lands mid-frame, the still-low pin
    // produces no fall, so the rest of that frame is ignored until CSN
    // rises and falls again.
    spi_edge_sync #(.STAGES(STG), .RESET_VAL(1'b0)) u_csn_sync (
        .clk  (clk),
        .reset(reset),
        .din  (spi.spi_csn),
        .rise (csn_rise),
        .fall (csn_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) sdi_chain <= '0;
        else       sdi_chain <= {sdi_chain[STG-2:0], spi.spi_sdi};
    end
    assign sdi_s = sdi_chain[STG-1];

    // FSM / shifter state
    logic [1:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] shift_in;
    logic [7:0] shift_out;
    logic       mb;
    logic [5:0] addr;
    logic       sdo_q;
    logic       sdo_oe_q;

    // Register file
    logic [7:0]  bw_rate, power_ctl, int_enable, int_map, data_format;
    logic        data_ready;
    logic [15:0] data_x, data_y, data_z;
    logic [15:0] pend_x, pend_y, pend_z;
    logic        pend_valid;

    logic [7:0] cmd_byte;
    logic [5:0] next_addr;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_load;
    logic       wr_en;
    logic       sample_take;
    logic       sample_direct;
    logic       apply_sample;
    logic       apply_pend;
    logic       dr_set;
    logic       dr_clr;
    logic       irq;

    assign cmd_byte  = {shift_in[6:0], sdi_s};
    assign next_addr = mb ? addr + 6'd1 : addr;
    // The command byte addresses the first read; later bytes use the
    // advanced (or repeated) address.
    assign rd_addr   = (state == ST_CMD) ? cmd_byte[5:0] : next_addr;

    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            ADDR_DEVID:       rd_data = DEVID;
            ADDR_BW_RATE:     rd_data = bw_rate;
            ADDR_POWER_CTL:   rd_data = power_ctl;
            ADDR_INT_ENABLE:  rd_data = int_enable;
            ADDR_INT_MAP:     rd_data = int_map;
            ADDR_INT_SOURCE:  rd_data[DATA_READY_BIT] = data_ready;
            ADDR_DATA_FORMAT: rd_data = data_format;
            ADDR_DATAX0:      rd_data = data_x[7:0];
            ADDR_DATAX1:      rd_data = data_x[15:8];
            ADDR_DATAY0:      rd_data = data_y[7:0];
            ADDR_DATAY1:      rd_data = data_y[15:8];
            ADDR_DATAZ0:      rd_data = data_z[7:0];
            ADDR_DATAZ1:      rd_data = data_z[15:8];
            default:          rd_data = 8'h00;
        endcase
    end

    always_comb begin
        rd_load = 1'b0;
        wr_en   = 1'b0;
        if (!csn_rise) begin
            if (state == ST_CMD && sclk_rise && bit_cnt == 3'd7 && cmd_byte[7])
                rd_load = 1'b1;
            if (state == ST_RDATA && sclk_fall && bit_cnt == 3'd7)
                rd_load = 1'b1;
            if (state == ST_WDATA && sclk_rise && bit_cnt == 3'd7)
                wr_en = 1'b1;
        end
    end

    // A sample arriving on the CSN-rise cycle is newer than the buffered
    // one, so it is applied directly and the buffer is discarded.
    always_comb begin
        sample_take   = sample_valid & power_ctl[MEASURE_BIT];
        sample_direct = (state == ST_IDLE) || csn_rise;
        apply_sample  = sample_take && sample_direct;
        apply_pend    = !apply_sample && csn_rise && pend_valid;
        dr_set        = apply_sample || apply_pend;
        dr_clr        = rd_load && is_data_addr(rd_addr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            shift_in  <= 8'h00;
            shift_out <= 8'h00;
            mb        <= 1'b0;
            addr      <= 6'd0;
            sdo_q     <= 1'b0;
            sdo_oe_q  <= 1'b0;
        end else if (csn_rise) begin
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
            sdo_q    <= 1'b0;
            sdo_oe_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (csn_fall) begin
                        state    <= ST_CMD;
                        bit_cnt  <= 3'd0;
                        sdo_q    <= 1'b0;
                        sdo_oe_q <= 1'b1;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        shift_in <= cmd_byte;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            mb   <= cmd_byte[6];
                            addr <= cmd_byte[5:0];
                            if (cmd_byte[7]) begin
                                shift_out <= rd_data;
                                state     <= ST_RDATA;
                            end else begin
                                state <= ST_WDATA;
                            end
                        end
                    end
                end
                ST_WDATA: begin
                    if (sclk_rise) begin
                        shift_in <= cmd_byte;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            addr <= next_addr;
                    end
                end
                ST_RDATA: begin
                    if (sclk_fall) begin
                        sdo_q   <= shift_out[7];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            shift_out <= rd_data;
                            addr      <= next_addr;
                        end else begin
                            shift_out <= {shift_out[6:0], 1'b0};
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bw_rate     <= BW_RATE_RST;
            power_ctl   <= 8'h00;
            int_enable  <= 8'h00;
            int_map     <= 8'h00;
            data_format <= 8'h00;
        end else if (wr_en) begin
            case (addr)
                ADDR_BW_RATE:     bw_rate     <= cmd_byte;
                ADDR_POWER_CTL:   power_ctl   <= cmd_byte;
                ADDR_INT_ENABLE:  int_enable  <= cmd_byte;
                ADDR_INT_MAP:     int_map     <= cmd_byte;
                ADDR_DATA_FORMAT: data_format <= cmd_byte;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_x     <= 16'h0000;
            data_y     <= 16'h0000;
            data_z     <= 16'h0000;
            pend_x     <= 16'h0000;
            pend_y     <= 16'h0000;
            pend_z     <= 16'h0000;
            pend_valid <= 1'b0;
            data_ready <= 1'b0;
        end else begin
            if (apply_sample) begin
                data_x <= sample_x;
                data_y <= sample_y;
                data_z <= sample_z;
            end else if (apply_pend) begin
                data_x <= pend_x;
                data_y <= pend_y;
                data_z <= pend_z;
            end

            if (sample_take && !sample_direct) begin
                pend_x     <= sample_x;
                pend_y     <= sample_y;
                pend_z     <= sample_z;
                pend_valid <= 1'b1;
            end else if (csn_rise) begin
                pend_valid <= 1'b0;
            end

            if (dr_set)      data_ready <= 1'b1;
            else if (dr_clr) data_ready <= 1'b0;
        end
    end

    assign irq = data_ready & int_enable[DATA_READY_BIT];

    always_ff @(posedge clk) begin
        if (reset) int_out <= 2'b00;
        else       int_out <= {irq & int_map[DATA_READY_BIT], irq & ~int_map[DATA_READY_BIT]};
    end

    assign spi.spi_sdo    = sdo_q;
    assign spi.spi_sdo_oe = sdo_oe_q;
endmodule

// File: tb/tb_gsensor_spi_responder.sv
module tb_gsensor_spi_responder;
    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sample_x, sample_y, sample_z;
    logic        sample_valid;
    logic [2:1]  int_out;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gsensor_spi_responder_if spi_bus ();

    gsensor_spi_responder dut (
        .clk         (clk),
        .reset       (reset),
        .spi         (spi_bus.slave),
        .sample_x    (sample_x),
        .sample_y    (sample_y),
        .sample_z    (sample_z),
        .sample_valid(sample_valid),
        .int_out     (int_out)
    );

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode 3 controller: drive SDI while SCLK low, capture SDO just before
    // the rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            spi_bus.spi_sclk = 1'b0;
            spi_bus.spi_sdi  = tx[i];
            wait_clk(HALF);
            rx[i] = spi_bus.spi_sdo;
            spi_bus.spi_sclk = 1'b1;
            wait_clk(HALF);
        end
    endtask

    task automatic cs_low();
        spi_bus.spi_csn = 1'b0;
        wait_clk(6);
    endtask

    task automatic cs_high();
        wait_clk(2);
        spi_bus.spi_csn = 1'b1;
        wait_clk(8);
    endtask

    task automatic reg_write(input logic [5:0] a, input logic [7:0] d);
        logic [7:0] rx;
        cs_low();
        spi_bits({2'b00, a}, 8, rx);
        spi_bits(d, 8, rx);
        cs_high();
    endtask

    task automatic reg_read(input logic [5:0] a, output logic [7:0] d);
        logic [7:0] rx;
        cs_low();
        spi_bits({2'b10, a}, 8, rx);
        spi_bits(8'h00, 8, d);
        cs_high();
    endtask

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        sample_x     = x;
        sample_y     = y;
        sample_z     = z;
        sample_valid = 1'b1;
        wait_clk(1);
        sample_valid = 1'b0;
        wait_clk(1);
    endtask

    task automatic test_reset();
        spi_bus.spi_csn  = 1'b1;
        spi_bus.spi_sclk = 1'b1;
        spi_bus.spi_sdi  = 1'b0;
        sample_x = 16'h0; sample_y = 16'h0; sample_z = 16'h0;
        sample_valid = 1'b0;
        reset = 1'b1;
        wait_clk(5);
        vectors++;
        if (spi_bus.spi_sdo !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_sdo got %b want 0", spi_bus.spi_sdo);
        end
        vectors++;
        if (spi_bus.spi_sdo_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_oe got %b want 0", spi_bus.spi_sdo_oe);
        end
        vectors++;
        if (int_out !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_int got %b want 00", int_out);
        end
        reset = 1'b0;
        wait_clk(10);
    endtask

    task automatic test_devid();
        logic [7:0] rx;
        reg_read(6'h00, rx);
        vectors++;
        if (rx !== 8'hE5) begin
            miscompares++;
            $display("FAIL devid got %h want e5", rx);
        end
        reg_read(6'h2C, rx);
        vectors++;
        if (rx !== 8'h0A) begin
            miscompares++;
            $display("FAIL bw_rate_rst got %h want 0a", rx);
        end
        // Single-byte mode repeats the same register.
        cs_low();
        vectors++;
        if (spi_bus.spi_sdo_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL oe_in_frame got %b want 1", spi_bus.spi_sdo_oe);
        end
        spi_bits(8'h80, 8, rx);
        for (int b = 0; b < 2; b++) begin
            spi_bits(8'h00, 8, rx);
            vectors++;
            if (rx !== 8'hE5) begin
                miscompares++;
                $display("FAIL devid_repeat[%0d] got %h want e5", b, rx);
            end
        end
        cs_high();
        vectors++;
        if (spi_bus.spi_sdo_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL oe_after_frame got %b want 0", spi_bus.spi_sdo_oe);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] rx;
        // Measurement off: sample must be dropped.
        pulse_sample(16'h5A5A, 16'h5A5A, 16'h5A5A);
        reg_read(6'h32, rx);
        vectors++;
        if (rx !== 8'h00) begin
            miscompares++;
            $display("FAIL dropped_sample got %h want 00", rx);
        end
        reg_read(6'h30, rx);
        vectors++;
        if (rx !== 8'h00) begin
            miscompares++;
            $display("FAIL dropped_dr got %h want 00", rx);
        end
        reg_write(6'h2D, 8'h08);
        reg_read(6'h2D, rx);
        vectors++;
        if (rx !== 8'h08) begin
            miscompares++;
            $display("FAIL power_ctl got %h want 08", rx);
        end
        reg_write(6'h32, 8'h55);
        reg_read(6'h32, rx);
        vectors++;
        if (rx !== 8'h00) begin
            miscompares++;
            $display("FAIL ro_datax0 got %h want 00", rx);
        end
        reg_write(6'h31, 8'h0B);
        reg_read(6'h31, rx);
        vectors++;
        if (rx !== 8'h0B) begin
            miscompares++;
            $display("FAIL data_format got %h want 0b", rx);
        end
    endtask

    task automatic test_sample_irq();
        logic [7:0] rx;
        logic [7:0] expv [6];
        expv[0] = 8'h23; expv[1] = 8'h01; expv[2] = 8'hFE;
        expv[3] = 8'hFF; expv[4] = 8'hFF; expv[5] = 8'h7F;
        reg_write(6'h2E, 8'h80);
        reg_write(6'h2F, 8'h00);
        vectors++;
        if (int_out !== 2'b00) begin
            miscompares++;
            $display("FAIL irq_idle got %b want 00", int_out);
        end
        pulse_sample(16'h0123, 16'hFFFE, 16'h7FFF);
        wait_clk(2);
        vectors++;
        if (int_out !== 2'b01) begin
            miscompares++;
            $display("FAIL irq_int1 got %b want 01", int_out);
        end
        reg_read(6'h30, rx);
        vectors++;
        if (rx !== 8'h80) begin
            miscompares++;
            $display("FAIL int_source got %h want 80", rx);
        end
        cs_low();
        spi_bits(8'hF2, 8, rx);
        for (int b = 0; b < 6; b++) begin
            spi_bits(8'h00, 8, rx);
            vectors++;
            if (rx !== expv[b]) begin
                miscompares++;
                $display("FAIL mb_read[%0d] got %h want %h", b, rx, expv[b]);
            end
            if (b == 0) begin
                vectors++;
                if (int_out !== 2'b00) begin
                    miscompares++;
                    $display("FAIL irq_cleared got %b want 00", int_out);
                end
            end
        end
        cs_high();
    endtask

    task automatic test_pending();
        logic [7:0] rx;
        logic [7:0] oldv [6];
        logic [7:0] newv [6];
        oldv[0] = 8'h23; oldv[1] = 8'h01; oldv[2] = 8'hFE;
        oldv[3] = 8'hFF; oldv[4] = 8'hFF; oldv[5] = 8'h7F;
        newv[0] = 8'h11; newv[1] = 8'h11; newv[2] = 8'h22;
        newv[3] = 8'h22; newv[4] = 8'h33; newv[5] = 8'h33;
        cs_low();
        spi_bits(8'hF2, 8, rx);
        pulse_sample(16'h1111, 16'h2222, 16'h3333);
        for (int b = 0; b < 6; b++) begin
            spi_bits(8'h00, 8, rx);
            vectors++;
            if (rx !== oldv[b]) begin
                miscompares++;
                $display("FAIL snapshot[%0d] got %h want %h", b, rx, oldv[b]);
            end
        end
        vectors++;
        if (int_out !== 2'b00) begin
            miscompares++;
            $display("FAIL pend_no_irq got %b want 00", int_out);
        end
        cs_high();
        vectors++;
        if (int_out !== 2'b01) begin
            miscompares++;
            $display("FAIL pend_irq got %b want 01", int_out);
        end
        cs_low();
        spi_bits(8'hF2, 8, rx);
        for (int b = 0; b < 6; b++) begin
            spi_bits(8'h00, 8, rx);
            vectors++;
            if (rx !== newv[b]) begin
                miscompares++;
                $display("FAIL pend_applied[%0d] got %h want %h", b, rx, newv[b]);
            end
        end
        cs_high();
    endtask

    task automatic test_int_map();
        logic [7:0] rx;
        reg_write(6'h2F, 8'h80);
        pulse_sample(16'h0A0B, 16'h0C0D, 16'h0E0F);
        wait_clk(2);
        vectors++;
        if (int_out !== 2'b10) begin
            miscompares++;
            $display("FAIL irq_int2 got %b want 10", int_out);
        end
        reg_read(6'h37, rx);
        vectors++;
        if (rx !== 8'h0E) begin
            miscompares++;
            $display("FAIL dataz1 got %h want 0e", rx);
        end
        vectors++;
        if (int_out !== 2'b00) begin
            miscompares++;
            $display("FAIL int2_cleared got %b want 00", int_out);
        end
    endtask

    task automatic test_partial_write();
        logic [7:0] rx;
        cs_low();
        spi_bits(8'h2E, 8, rx);
        spi_bits(8'h00, 5, rx);
        cs_high();
        reg_read(6'h2E, rx);
        vectors++;
        if (rx !== 8'h80) begin
            miscompares++;
            $display("FAIL partial_write got %h want 80", rx);
        end
        reg_read(6'h00, rx);
        vectors++;
        if (rx !== 8'hE5) begin
            miscompares++;
            $display("FAIL after_partial got %h want e5", rx);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        logic [5:0] addrs [6];
        logic [7:0] expv  [6];
        addrs[0] = 6'h2C; expv[0] = 8'h0A;
        addrs[1] = 6'h2D; expv[1] = 8'h00;
        addrs[2] = 6'h2E; expv[2] = 8'h00;
        addrs[3] = 6'h2F; expv[3] = 8'h00;
        addrs[4] = 6'h31; expv[4] = 8'h00;
        addrs[5] = 6'h32; expv[5] = 8'h00;
        cs_low();
        spi_bits(8'hAD, 8, rx);
        spi_bits(8'h00, 3, rx);
        vectors++;
        if (spi_bus.spi_sdo_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL oe_rdata got %b want 1", spi_bus.spi_sdo_oe);
        end
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        vectors++;
        if (spi_bus.spi_sdo_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL oe_after_reset got %b want 0", spi_bus.spi_sdo_oe);
        end
        // Rest of the aborted frame must be ignored.
        spi_bits(8'hFF, 5, rx);
        spi_bits(8'hFF, 8, rx);
        vectors++;
        if (spi_bus.spi_sdo_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL oe_aborted_frame got %b want 0", spi_bus.spi_sdo_oe);
        end
        cs_high();
        for (int k = 0; k < 6; k++) begin
            reg_read(addrs[k], rx);
            vectors++;
            if (rx !== expv[k]) begin
                miscompares++;
                $display("FAIL reset_reg[%h] got %h want %h", addrs[k], rx, expv[k]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] rx;
        logic [7:0] expv [2];
        expv[0] = 8'h00; expv[1] = 8'hE5;
        cs_low();
        spi_bits(8'hFF, 8, rx);
        for (int b = 0; b < 2; b++) begin
            spi_bits(8'h00, 8, rx);
            vectors++;
            if (rx !== expv[b]) begin
                miscompares++;
                $display("FAIL wrap[%0d] got %h want %h", b, rx, expv[b]);
            end
        end
        cs_high();
    endtask

    initial begin
        test_reset();
        test_devid();
        test_write_read();
        test_sample_irq();
        test_pending();
        test_int_map();
        test_partial_write();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
